display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Shares the board's single 8-digit hex display between up to NREQ requesters, e.g. register file probe, PC, memory probe and ALU result.
- Round-robin arbitration with a minimum dwell time per owner, then a blanking gap between owners so hand-over is visible.
- disp_val drives the 8-digit display driver's val input.
- At top level, disp_blank forces digitselect to all-ones (all digits off).

Parameters:
- NREQ, 4: number of requesters, 2..8.
- DWELL_CYCLES, 100000000: minimum clock cycles an owner is shown; must be ≥1.
- BLANK_CYCLES, 2000000: cycles the display is blanked between owners; must be ≥1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a value to show.
- req_val  in  NREQ*32  value of requester i in bits [32*i+31:32*i].
- req_ready  out  NREQ  handshake accept; a transfer happens when valid&ready in the same cycle.
- lock  in  1  freezes the current owner (debug switch).
- disp_val  out  32  value presented to the display.
- disp_blank  out  1  1 = display dark.
- owner  out  $clog2(NREQ)  index of the current owner.
- owner_valid  out  1  1 while in SHOW.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=IDLE, disp_val=0, disp_blank=1, owner=0, owner_valid=0, cnt=0.
  - Round-robin pointer last=NREQ-1, so the first search starts at index 0.
  - req_ready is combinational, and 0 in IDLE when no req_valid is asserted.
  - Reset asserted mid-operation returns everything to these values immediately; no handshake completes in that cycle.
- IDLE:
  - disp_blank=1, owner_valid=0.
  - Grant g = first i with req_valid[i], searching from (last+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; only one bit is ever set.
  - Next cycle: disp_val=req_val[g], owner=g, last=g, owner_valid=1, disp_blank=0, cnt=0, state=SHOW.
  - With no valid requester, stay in IDLE with outputs held.
- SHOW:
  - req_ready[owner]=1; all other ready bits 0.
  - Owner may stream updates: each valid&ready cycle loads disp_val on the next edge.
  - cnt increments each cycle, saturating at DWELL_CYCLES-1.
  - Leave SHOW only when cnt==DWELL_CYCLES-1, lock==0, and some req_valid[j]=1 with j≠owner. Then go to BLANK with cnt=0.
  - An owner update accepted in that same cycle is still loaded into disp_val.
  - If no other requester is waiting, stay in SHOW indefinitely; switch on the first cycle another becomes valid.
  - lock=1 holds SHOW regardless of cnt. Dropping lock with cnt saturated and another requester waiting leaves SHOW next cycle.
  - The owner dropping req_valid does not end SHOW; the last value stays shown.
- BLANK:
  - disp_blank=1, owner_valid=0, all req_ready=0, disp_val and owner held.
  - cnt counts to BLANK_CYCLES-1, then state=IDLE, cnt=0.
  - The former owner may be re-granted in IDLE if it is the only valid requester.
- Requesters may drop req_valid without a handshake; the arbiter never reorders values.
- Widths:
  - cnt is $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) bits, unsigned, with no wrap (saturating/reset only).
  - The owner index wraps modulo NREQ, correct for non-power-of-two NREQ.
- Latency: grant to displayed value is 1 cycle. Dwell expiry to next owner shown is BLANK_CYCLES+2 cycles (1 cycle into BLANK, BLANK_CYCLES cycles in BLANK, 1 IDLE grant cycle).

Decomposition:
- Package display_pkg holds:
  - state enum {IDLE, SHOW, BLANK}
  - VAL_W=32
  - NUM_DIGITS=8
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], mask[NREQ], last.
  - Outputs: gnt_idx, gnt_any.
  - Mask excludes the owner when checking for waiting requesters in SHOW; it is all-ones in IDLE.
- Counter and FSM live in display_scheduler.

Test Plan (NREQ=4, DWELL_CYCLES=8, BLANK_CYCLES=3):
- Reset, then req_valid=0001 with val0=0x12345678 → req_ready=0001 for 1 cycle; next cycle disp_val=0x12345678, owner=0, disp_blank=0. Shows indefinitely while no other requester is valid.
- Owner 0 streams 0xA, then 0xB on consecutive cycles during SHOW → disp_val follows one cycle later each time; req_ready[1..3] stay 0.
- req_valid=1111 held constant → owners cycle 0,1,2,3,0. Each SHOW lasts 8 cycles, followed by 3 BLANK cycles and 1 IDLE cycle (12-cycle period).
- lock=1 while owner=2 and others valid for 50 cycles → owner stays 2. Release lock → disp_blank=1 on the next cycle, then owner=3.
- During SHOW of owner 1, req_valid[3] rises at cnt=2 and drops at cnt=5 → no switch at dwell expiry; owner stays 1.
- Assert reset_n=0 during BLANK → outputs immediately at reset values. After release, arbitration restarts from index 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display scheduler
package display_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  localparam int VAL_W = 32;
  localparam int NUM_DIGITS = 8;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/display_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker, first masked request after last
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);
  always_comb begin
    int j;
    j = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // walk from farthest to nearest so the nearest hit after last wins
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(last) + k) % NREQ;
      if (req[j] && mask[j]) begin
        gnt_idx = IW'(j);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin owner of the hex display with dwell and blanking gap
module display_scheduler
  import display_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int BLANK_CYCLES = 2000000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*VAL_W-1:0]     req_val,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      lock,
  output logic [VAL_W-1:0]          disp_val,
  output logic                      disp_blank,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      owner_valid
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(max2(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] last, last_n, owner_n, gnt_idx;
  logic [VAL_W-1:0] val_n;
  logic [VAL_W-1:0] vals [NREQ];
  logic gnt_any;
  always_comb for (int i = 0; i < NREQ; i++) vals[i] = req_val[i*VAL_W +: VAL_W];
  // in SHOW the picker only answers "is anyone else waiting", so the owner is masked out
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .mask    ((state == SHOW) ? ~(NREQ'(1) << owner) : {NREQ{1'b1}}),
    .last    ((state == SHOW) ? owner : last),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );
  assign disp_blank  = (state != SHOW);
  assign owner_valid = (state == SHOW);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_n = last;
    owner_n = owner;
    val_n = disp_val;
    req_ready = '0;
    case (state)
      IDLE: if (gnt_any) begin
        req_ready[gnt_idx] = reset_n;
        state_n = SHOW;
        cnt_n = '0;
        last_n = gnt_idx;
        owner_n = gnt_idx;
        val_n = vals[gnt_idx];
      end
      SHOW: begin
        req_ready[owner] = reset_n;
        val_n = req_valid[owner] ? vals[owner] : disp_val;
        cnt_n = (cnt == DWELL_END) ? cnt : cnt + 1'b1;
        if (cnt == DWELL_END && !lock && gnt_any) begin
          state_n = BLANK;
          cnt_n = '0;
        end
      end
      default: begin
        state_n = (cnt == BLANK_END) ? IDLE : BLANK;
        cnt_n = (cnt == BLANK_END) ? '0 : cnt + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= IW'(NREQ - 1);
      owner <= '0;
      disp_val <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last <= last_n;
      owner <= owner_n;
      disp_val <= val_n;
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of arbitration, dwell, blanking, lock and reset
module tb_display_scheduler;
  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] req_valid;
  logic [127:0] req_val;
  logic [3:0] req_ready;
  logic lock;
  logic [31:0] disp_val;
  logic disp_blank;
  logic [1:0] owner;
  logic owner_valid;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  display_scheduler #(.NREQ(4), .DWELL_CYCLES(8), .BLANK_CYCLES(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_val     (req_val),
    .req_ready   (req_ready),
    .lock        (lock),
    .disp_val    (disp_val),
    .disp_blank  (disp_blank),
    .owner       (owner),
    .owner_valid (owner_valid)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic setv(input int i, input logic [31:0] v);
    req_val[i*32 +: 32] = v;
  endtask
  task automatic shown(input string tag, input logic [1:0] o, input logic [31:0] v);
    check({tag, "_owner"}, 32'(owner), 32'(o));
    check({tag, "_ovalid"}, 32'(owner_valid), 32'd1);
    check({tag, "_blank"}, 32'(disp_blank), 32'd0);
    check({tag, "_val"}, disp_val, v);
  endtask
  initial begin
    reset_n = 1'b1;
    req_valid = '0;
    req_val = '0;
    lock = 1'b0;
    #1 reset_n = 1'b0;
    tick();
    check("rst_val", disp_val, 32'h0);
    check("rst_blank", 32'(disp_blank), 32'd1);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_ovalid", 32'(owner_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_ready_none", 32'(req_ready), 32'd0);
    req_valid = 4'b0001;
    setv(0, 32'h12345678);
    #1 check("grant0_ready", 32'(req_ready), 32'b0001);
    tick();
    shown("show0", 2'd0, 32'h12345678);
    setv(0, 32'hA);
    tick();
    check("stream_a", disp_val, 32'hA);
    setv(0, 32'hB);
    tick();
    check("stream_b", disp_val, 32'hB);
    check("stream_ready", 32'(req_ready), 32'b0001);
    repeat (20) tick();
    shown("hold0", 2'd0, 32'hB);
    for (int i = 0; i < 4; i++) setv(i, 32'hC0DE0000 + 32'(i));
    req_valid = 4'b1111;
    #1 check("rr_ready0", 32'(req_ready), 32'b0001);
    tick();
    check("blank0_blank", 32'(disp_blank), 32'd1);
    check("blank0_ovalid", 32'(owner_valid), 32'd0);
    check("blank0_ready", 32'(req_ready), 32'd0);
    check("blank0_lastval", disp_val, 32'hC0DE0000);
    repeat (3) tick();
    check("idle_ready1", 32'(req_ready), 32'b0010);
    tick();
    shown("rr1", 2'd1, 32'hC0DE0001);
    for (int k = 2; k <= 4; k++) begin
      repeat (7) tick();
      check("rr_still_show", 32'(owner_valid), 32'd1);
      tick();
      check("rr_blank", 32'(disp_blank), 32'd1);
      repeat (4) tick();
      shown("rr_next", 2'(k % 4), 32'hC0DE0000 + 32'(k % 4));
    end
    repeat (24) tick();
    shown("rr2_again", 2'd2, 32'hC0DE0002);
    lock = 1'b1;
    repeat (50) tick();
    shown("lock_hold", 2'd2, 32'hC0DE0002);
    lock = 1'b0;
    tick();
    check("unlock_blank", 32'(disp_blank), 32'd1);
    repeat (4) tick();
    shown("unlock_next", 2'd3, 32'hC0DE0003);
    req_valid = 4'b0010;
    repeat (12) tick();
    shown("own1", 2'd1, 32'hC0DE0001);
    repeat (2) tick();
    req_valid = 4'b1010;
    #1 check("own1_ready", 32'(req_ready), 32'b0010);
    repeat (3) tick();
    req_valid = 4'b0010;
    repeat (10) tick();
    shown("own1_stay", 2'd1, 32'hC0DE0001);
    req_valid = 4'b1010;
    tick();
    check("pre_rst_blank", 32'(disp_blank), 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_val", disp_val, 32'h0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    check("mid_rst_blank", 32'(disp_blank), 32'd1);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    req_valid = 4'b1111;
    #1 check("restart_ready", 32'(req_ready), 32'b0001);
    tick();
    shown("restart", 2'd0, 32'hC0DE0000);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
